// File: rtl/serial_tx_if.sv
// Handshake and line bundle between a word producer and serial_tx.
// The producer drives data/valid; the transmitter drives ready, tx and busy.
interface serial_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 tx;
    logic                 busy;

    modport master (output data, output valid, input ready, input tx, input busy);
    modport slave  (input data, input valid, output ready, output tx, output busy);
endinterface

// File: rtl/serial_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first payload, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between payload and stop.
module serial_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int DELAY_RISE   = 0,
    parameter int DELAY_FALL   = 0
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 baud_end;
    logic                 accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);
    // ready_q is high exactly in IDLE and the final STOP cycle, so it gates every transfer
    assign accept   = ready_q & bus.valid;

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_START;
                    shift_d   = bus.data;
                    baud_d    = '0;
                    bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^bus.data;
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d    = '0;
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Back-to-back: a word offered in the last stop cycle starts the next frame directly
                    if (accept) begin
                        state_d   = ST_START;
                        shift_d   = bus.data;
                        bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        parity_d  = ^bus.data;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE) || ((state_d == ST_STOP) && (baud_d == BAUD_LAST));
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
        parity_q <= parity_d;
`endif
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign #(DELAY_RISE, DELAY_FALL) bus.tx    = tx_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.ready = ready_q;
    assign #(DELAY_RISE, DELAY_FALL) bus.busy  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: three instances (4, 1 and 2 clocks per bit), frames compared
// as time-ordered bit vectors {stop, [parity,] payload, start} written out by hand.
module tb_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] vld;
    logic [7:0] dat [3];
    logic [2:0] txv, rdyv, bsyv;

    serial_tx_if #(.DATA_BITS(8)) if4 ();
    serial_tx_if #(.DATA_BITS(8)) if1 ();
    serial_tx_if #(.DATA_BITS(8)) if2 ();

    assign if4.valid = vld[0];
    assign if4.data  = dat[0];
    assign if1.valid = vld[1];
    assign if1.data  = dat[1];
    assign if2.valid = vld[2];
    assign if2.data  = dat[2];
    assign txv  = {if2.tx, if1.tx, if4.tx};
    assign rdyv = {if2.ready, if1.ready, if4.ready};
    assign bsyv = {if2.busy, if1.busy, if4.busy};

    serial_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) u_tx4 (.clk(clk), .reset(reset), .bus(if4));
    serial_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8)) u_tx1 (.clk(clk), .reset(reset), .bus(if1));
    serial_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) u_tx2 (.clk(clk), .reset(reset), .bus(if2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a word for one edge (the handshake edge E0); returns in cycle 1 after E0.
    task automatic send(input int sel, input logic [7:0] d, input bit hold);
        dat[sel] = d;
        vld[sel] = 1'b1;
        tick();
        if (!hold) vld[sel] = 1'b0;
    endtask

    // Samples cycles 1..nbits*cpb of a frame; bit k taken from its first cycle, any change
    // inside a bit period flags a glitch. Returns in the last cycle of the frame.
    task automatic capture(input int sel, input int nbits, input int cpb, input bit toggle,
                           output logic [31:0] bits, output logic glitch,
                           output logic rdy_pre, output logic rdy_last);
        int total;
        total    = nbits * cpb;
        bits     = '0;
        glitch   = 1'b0;
        rdy_pre  = 1'b0;
        rdy_last = 1'b0;
        for (int n = 1; n <= total; n++) begin
            int k;
            k = (n - 1) / cpb;
            if ((n - 1) % cpb == 0) bits[k] = txv[sel];
            else if (txv[sel] !== bits[k]) glitch = 1'b1;
            if (n == total - 1) rdy_pre = rdyv[sel];
            if (n == total) rdy_last = rdyv[sel];
            if (toggle) vld[sel] = (n < total) ? ~vld[sel] : 1'b0;
            if (n < total) tick();
        end
    endtask

    logic [31:0] bits;
    logic        glitch, rdy_pre, rdy_last;

    initial begin
        reset = 1'b1;
        vld   = '0;
        for (int i = 0; i < 3; i++) dat[i] = 8'h00;
        tick();
        tick();
        check("rst_tx",    32'(txv),  32'h7);
        check("rst_ready", 32'(rdyv), 32'h7);
        check("rst_busy",  32'(bsyv), 32'h0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(bsyv), 32'h0);

        // Single frame 0x55, 4 clocks per bit
        send(0, 8'h55, 1'b0);
        check("f55_busy_c1",  32'(bsyv[0]), 32'd1);
        check("f55_ready_c1", 32'(rdyv[0]), 32'd0);
        capture(0, 10, 4, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("f55_frame",   bits,            32'h2AA);
        check("f55_glitch",  32'(glitch),     32'd0);
        check("f55_rdy_c39", 32'(rdy_pre),    32'd0);
        check("f55_rdy_c40", 32'(rdy_last),   32'd1);
        tick();
        check("f55_idle_busy", 32'(bsyv[0]), 32'd0);
        check("f55_idle_tx",   32'(txv[0]),  32'd1);

        // Back-to-back 0xA5 then 0x3C with valid held
        send(0, 8'hA5, 1'b1);
        dat[0] = 8'h3C;
        capture(0, 10, 4, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("b2b_a5_frame",  bits,          32'h34A);
        check("b2b_a5_rdy",    32'(rdy_last), 32'd1);
        tick();
        vld[0] = 1'b0;
        check("b2b_c41_busy",  32'(bsyv[0]), 32'd1);
        capture(0, 10, 4, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("b2b_3c_frame",  bits,          32'h278);
        check("b2b_3c_glitch", 32'(glitch),   32'd0);
        tick();
        check("b2b_end_busy",  32'(bsyv[0]), 32'd0);

        // Mid-frame reset at cycle 10 of a 0x00 frame
        send(0, 8'h00, 1'b0);
        repeat (9) tick();
        check("mrst_pre_tx",   32'(txv[0]),  32'd0);
        check("mrst_pre_busy", 32'(bsyv[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_tx",    32'(txv[0]),  32'd1);
        check("mrst_ready", 32'(rdyv[0]), 32'd1);
        check("mrst_busy",  32'(bsyv[0]), 32'd0);
        tick();
        check("mrst_stays_idle", 32'(bsyv[0]), 32'd0);
        send(0, 8'hC3, 1'b0);
        capture(0, 10, 4, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("mrst_c3_frame",  bits,        32'h386);
        check("mrst_c3_glitch", 32'(glitch), 32'd0);
        tick();

        // Data/valid changes while busy must not disturb the frame
        send(0, 8'hF0, 1'b0);
        dat[0] = 8'h0F;
        vld[0] = 1'b1;
        capture(0, 10, 4, 1'b1, bits, glitch, rdy_pre, rdy_last);
        check("stab_frame",  bits,        32'h3E0);
        check("stab_glitch", 32'(glitch), 32'd0);
        tick();
        check("stab_no_extra_busy", 32'(bsyv[0]), 32'd0);
        check("stab_no_extra_tx",   32'(txv[0]),  32'd1);
        tick();
        check("stab_still_idle", 32'(bsyv[0]), 32'd0);

        // One clock per bit: 0x81
        send(1, 8'h81, 1'b0);
        capture(1, 10, 1, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("cpb1_frame",   bits,          32'h302);
        check("cpb1_rdy_c9",  32'(rdy_pre),  32'd0);
        check("cpb1_rdy_c10", 32'(rdy_last), 32'd1);
        tick();
        check("cpb1_idle_busy", 32'(bsyv[1]), 32'd0);

        // Two clocks per bit, with or without the parity bit
`ifdef SERIAL_TX_PARITY_EN
        send(2, 8'h07, 1'b0);
        capture(2, 11, 2, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("par07_frame",  bits,          32'h60E);
        check("par07_rdy21",  32'(rdy_pre),  32'd0);
        check("par07_rdy22",  32'(rdy_last), 32'd1);
        tick();
        send(2, 8'h03, 1'b0);
        capture(2, 11, 2, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("par03_frame",  bits,          32'h406);
        check("par03_glitch", 32'(glitch),   32'd0);
        tick();
`else
        send(2, 8'h07, 1'b0);
        capture(2, 10, 2, 1'b0, bits, glitch, rdy_pre, rdy_last);
        check("cpb2_frame",  bits,          32'h20E);
        check("cpb2_rdy19",  32'(rdy_pre),  32'd0);
        check("cpb2_rdy20",  32'(rdy_last), 32'd1);
        tick();
`endif
        check("cpb2_idle_busy", 32'(bsyv[2]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Byte-serial asynchronous transmitter. It accepts a parallel word over a valid/ready handshake and shifts it out on a single line, LSB first, framed by a start bit and a stop bit. It is the transmit end of the CPU's serial console link and pairs with the console receiver on the far side of the wire. It sits between the CPU's I/O output latch and the TX pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 1 or greater.
- `DATA_BITS`, default 8: payload bits per frame. Legal range is 5 to 9.
- `DELAY_RISE`, default 0: rise delay applied to `tx`, `ready` and `busy` outputs (simulation only).
- `DELAY_FALL`, default 0: fall delay applied to the same outputs.

Ports:
- `clk`  in  1  system clock; every state change happens on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `data`  in  DATA_BITS  word to send; sampled only at handshake.
- `valid`  in  1  producer has a word on `data`.
- `ready`  out  1  transmitter can accept a word.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.

## Operation

- States: IDLE, START, DATA, PARITY (present only when the parity feature is compiled in), STOP.
- Registers:
  - shift register, DATA_BITS wide.
  - bit counter, `$clog2(DATA_BITS+1)` bits wide.
  - baud counter, `$clog2(CLKS_PER_BIT)` bits wide, minimum 1 bit.
- IDLE:
  - Outputs are `ready`=1, `busy`=0, `tx`=1.
  - On an edge with `valid`=1: load `data` into the shift register, clear both counters, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - `tx` = shift register bit 0.
  - When the baud counter reaches CLKS_PER_BIT-1: shift right and increment the bit counter.
  - After DATA_BITS bits: go to PARITY, or to STOP if parity is not compiled in.
- PARITY: `tx` = even parity bit (XOR of all captured data bits) for CLKS_PER_BIT cycles.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - On the last cycle: if `valid`=1, accept the new word and go straight to START (back-to-back, no idle gap). Otherwise go to IDLE.
- `ready` is 1 in IDLE and in the last cycle of STOP; it is 0 everywhere else.
- `busy` is 1 in every state except IDLE.
- Handshake rules:
  - A transfer occurs on an edge where `valid` and `ready` are both 1.
  - While `ready`=0, `valid` and `data` are ignored. Changing `data` mid-frame has no effect on the frame in flight.
  - `valid` may drop without a transfer; no penalty.
- Reset:
  - Asserted at any time, including mid-frame: the next edge forces IDLE, `tx`=1, `ready`=1, `busy`=0, and clears all counters.
  - A partial frame is abandoned, with no stop bit inserted.
  - While `reset`=1, `valid` is ignored.
- Reset value of every output: `tx`=1, `ready`=1, `busy`=0.

## Timing

- Call the handshake edge E0. Then:
  - `tx` falls, `busy` rises and `ready` falls at E0, visible in the cycle after E0.
  - Start bit covers cycles 1 to CLKS_PER_BIT after E0.
  - Data bit k covers cycles (k+1)·CLKS_PER_BIT+1 to (k+2)·CLKS_PER_BIT.
- Frame length:
  - Without parity: (DATA_BITS+2)·CLKS_PER_BIT cycles.
  - With parity: (DATA_BITS+3)·CLKS_PER_BIT cycles.
- Back-to-back frames repeat exactly every frame length.
- CLKS_PER_BIT=1:
  - Each state lasts one cycle.
  - Frame is 10 cycles for 8 data bits without parity.
- Outputs are registered; there is no combinational path from `valid` or `data` to `tx`.
- The `#(DELAY_RISE, DELAY_FALL)` delay is applied only on the final output assigns.

## Configuration

- Macro: `SERIAL_TX_PARITY_EN`.
- Defined: the PARITY state is inserted between DATA and STOP and carries even parity over the DATA_BITS payload. Frame length is (DATA_BITS+3)·CLKS_PER_BIT.
- Undefined: there is no PARITY state and no parity logic. Frame length is (DATA_BITS+2)·CLKS_PER_BIT.

## Test plan

- Single frame, CLKS_PER_BIT=4, no parity: send `data`=0x55 with a one-cycle `valid`.
  - `tx` reads 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles.
  - `ready` returns to 1 in cycle 40 after E0.
- Back-to-back: send 0xA5 then 0x3C with `valid` held high.
  - Second start bit begins exactly 40 cycles after the first.
  - Payloads decode as LSB-first 0xA5 then 0x3C.
- Mid-frame reset: assert `reset` for 1 cycle at cycle 10 of a 0x00 frame.
  - Next edge: `tx`=1, `ready`=1, `busy`=0.
  - A new `valid` after reset is accepted and produces a full, correct frame.
- Data stability: change `data` from 0xF0 to 0x0F and toggle `valid` while `busy`=1.
  - The frame on `tx` carries 0xF0.
  - No extra frame starts until `ready`=1.
- Parity, `SERIAL_TX_PARITY_EN` defined, CLKS_PER_BIT=2:
  - 0x07 gives parity bit 1; 0x03 gives parity bit 0.
  - Frame length is 22 cycles.
- CLKS_PER_BIT=1: send 0x81.
  - `tx` sequence is 0,1,0,0,0,0,0,0,1,1 on consecutive cycles.
